// File: rtl/pixel_readout.sv
// Captures one digitised pixel row per stable one-hot row select into a two-entry
// ping-pong buffer and streams each row out pixel by pixel over valid/ready.
module pixel_readout #(
    parameter int unsigned PIXEL_ARRAY_WIDTH  = 4,
    parameter int unsigned PIXEL_ARRAY_HEIGHT = 4,
    parameter int unsigned PIXEL_BITS         = 8,
    localparam int unsigned ROW_W = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1,
    localparam int unsigned COL_W = (PIXEL_ARRAY_WIDTH > 1) ? $clog2(PIXEL_ARRAY_WIDTH) : 1,
    localparam int unsigned BUS_W = PIXEL_ARRAY_WIDTH * PIXEL_BITS
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [PIXEL_ARRAY_HEIGHT-1:0] p_row_select,
    input  logic [BUS_W-1:0]              p_data,
    output logic [PIXEL_BITS-1:0]         o_data,
    output logic                          o_valid,
    input  logic                          o_ready,
    output logic [ROW_W-1:0]              o_row,
    output logic [COL_W-1:0]              o_col,
    output logic                          o_last,
    output logic                          o_overflow,
    output logic                          o_sel_error
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t                        r_state;
    state_t                        w_state_n;

    logic [PIXEL_ARRAY_HEIGHT-1:0] r_sel_q;
    logic                          r_cap_done;
    logic                          w_cap_done_n;
    logic [1:0]                    r_full;
    logic [1:0]                    w_full_n;
    logic                          r_wr_ptr;
    logic                          w_wr_ptr_n;
    logic                          r_rd_ptr;
    logic                          w_rd_ptr_n;
    logic [BUS_W-1:0]              r_buf [2];
    logic [ROW_W-1:0]              r_buf_row [2];
    logic [BUS_W-1:0]              w_entry_n;
    logic [ROW_W-1:0]              w_entry_row_n;

    logic [COL_W-1:0]              r_col;
    logic [COL_W-1:0]              w_col_n;
    logic                          r_valid;
    logic                          w_valid_n;
    logic [PIXEL_BITS-1:0]         r_data;
    logic [PIXEL_BITS-1:0]         w_data_n;
    logic [ROW_W-1:0]              r_row;
    logic [ROW_W-1:0]              w_row_n;
    logic                          r_last;
    logic                          w_last_n;
    logic                          r_overflow;
    logic                          r_sel_error;

    logic                          w_stable;
    logic                          w_nonzero;
    logic                          w_onehot;
    logic                          w_capture;
    logic                          w_store;
    logic                          w_drop;
    logic                          w_multi_err;
    logic                          w_xfer;
    logic                          w_row_done;
    logic [ROW_W-1:0]              w_sel_idx;

    // Select qualification: a capture needs the same one-hot value on two consecutive edges.
    assign w_stable    = (p_row_select == r_sel_q);
    assign w_nonzero   = |p_row_select;
    assign w_onehot    = w_nonzero &&
                         ((p_row_select & (p_row_select - PIXEL_ARRAY_HEIGHT'(1))) == '0);
    assign w_capture   = w_stable && w_onehot && !r_cap_done;
    assign w_store     = w_capture && !r_full[r_wr_ptr];
    assign w_drop      = w_capture && r_full[r_wr_ptr];
    assign w_multi_err = w_stable && w_nonzero && !w_onehot;
    assign w_xfer      = r_valid && o_ready;
    assign w_row_done  = w_xfer && r_last;

    always_comb begin
        w_sel_idx = '0;
        for (int i = 0; i < int'(PIXEL_ARRAY_HEIGHT); i++) begin
            if (p_row_select[i]) begin
                w_sel_idx = ROW_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    // Next buffer bookkeeping, FSM transition and next output word.
    always_comb begin
        w_state_n     = r_state;
        w_full_n      = r_full;
        w_wr_ptr_n    = r_wr_ptr;
        w_rd_ptr_n    = r_rd_ptr;
        w_col_n       = r_col;
        w_cap_done_n  = r_cap_done;
        w_valid_n     = 1'b0;
        w_data_n      = '0;
        w_row_n       = '0;
        w_last_n      = 1'b0;
        w_entry_n     = '0;
        w_entry_row_n = '0;

        if (!w_stable) begin
            w_cap_done_n = 1'b0;
        end else if (w_capture) begin
            w_cap_done_n = 1'b1;
        end

        if (w_store) begin
            w_full_n[r_wr_ptr] = 1'b1;
            w_wr_ptr_n         = ~r_wr_ptr;
        end

        if (w_xfer) begin
            if (r_last) begin
                w_full_n[r_rd_ptr] = 1'b0;
                w_rd_ptr_n         = ~r_rd_ptr;
                w_col_n            = '0;
            end else begin
                w_col_n = r_col + COL_W'(1);
            end
        end

        case (r_state)
            S_IDLE: begin
                if (|w_full_n) begin
                    w_state_n = S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_row_done && !w_full_n[w_rd_ptr_n]) begin
                    w_state_n = S_IDLE;
                end
            end
            default: w_state_n = S_IDLE;
        endcase

        w_valid_n = (w_state_n == S_STREAM);

        // A row written on this edge into the entry about to be read is forwarded directly.
        if (w_store && (r_wr_ptr == w_rd_ptr_n)) begin
            w_entry_n     = p_data;
            w_entry_row_n = w_sel_idx;
        end else begin
            w_entry_n     = r_buf[w_rd_ptr_n];
            w_entry_row_n = r_buf_row[w_rd_ptr_n];
        end

        if (w_valid_n) begin
            for (int c = 0; c < int'(PIXEL_ARRAY_WIDTH); c++) begin
                if (w_col_n == COL_W'(c)) begin
                    w_data_n = w_entry_n[c*PIXEL_BITS +: PIXEL_BITS];
                end
            end
            w_row_n  = w_entry_row_n;
            w_last_n = (w_col_n == COL_W'(PIXEL_ARRAY_WIDTH - 1));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sel_q     <= '0;
            r_cap_done  <= 1'b0;
            r_full      <= '0;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_col       <= '0;
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_row       <= '0;
            r_last      <= 1'b0;
            r_overflow  <= 1'b0;
            r_sel_error <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_buf[i]     <= '0;
                r_buf_row[i] <= '0;
            end
        end else begin
            r_sel_q     <= p_row_select;
            r_cap_done  <= w_cap_done_n;
            r_full      <= w_full_n;
            r_wr_ptr    <= w_wr_ptr_n;
            r_rd_ptr    <= w_rd_ptr_n;
            r_col       <= w_col_n;
            r_valid     <= w_valid_n;
            r_data      <= w_data_n;
            r_row       <= w_row_n;
            r_last      <= w_last_n;
            r_overflow  <= r_overflow | w_drop;
            r_sel_error <= r_sel_error | w_multi_err;
            if (w_store) begin
                r_buf[r_wr_ptr]     <= p_data;
                r_buf_row[r_wr_ptr] <= w_sel_idx;
            end
        end
    end

    assign o_data      = r_data;
    assign o_valid     = r_valid;
    assign o_row       = r_row;
    assign o_col       = r_col;
    assign o_last      = r_last;
    assign o_overflow  = r_overflow;
    assign o_sel_error = r_sel_error;

endmodule
